// File: rtl/byte_link_pkg.sv
// byte_link_pkg
// Shared definitions for the byte link arbiter slice: the FSM state
// encoding and the word/byte widths used by the arbiter and its datapath.
package byte_link_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    // Arbiter sequence: pick a requester, capture its word, acknowledge it,
    // then alternate SEND/COUNT once per byte.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ACK   = 3'd2,
        SEND  = 3'd3,
        COUNT = 3'd4
    } state_t;

endpackage

// File: rtl/byte_link_dp.sv
// byte_link_dp
// Datapath for the byte link: a 16-bit holding register for the granted
// word, a 1-bit byte counter and the output byte mux.
// Ports:
//   clk        system clock, all updates on the rising edge
//   rst        synchronous active-high reset, clears register and counter
//   load_word  capture word_in and restart the byte counter
//   advance    step the byte counter (wraps after the low byte)
//   drive_out  present the selected byte; otherwise out_byte is forced to 0
//   word_in    word of the granted requester
//   out_byte   high byte while counter is 0, low byte while counter is 1
//   byte_cnt   current byte counter value, used by the FSM to end a word
module byte_link_dp
    import byte_link_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_word,
    input  logic              advance,
    input  logic              drive_out,
    input  logic [WORD_W-1:0] word_in,
    output logic [BYTE_W-1:0] out_byte,
    output logic              byte_cnt
);

    logic [WORD_W-1:0] hold_word;

    // Capturing a new word always restarts at the high byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_word <= '0;
            byte_cnt  <= 1'b0;
        end else if (load_word) begin
            hold_word <= word_in;
            byte_cnt  <= 1'b0;
        end else if (advance) begin
            byte_cnt  <= ~byte_cnt;
        end
    end

    // The byte is only driven while it is offered downstream so the bus
    // reads as zero at all other times.
    always_comb begin
        out_byte = '0;
        if (drive_out) begin
            out_byte = byte_cnt ? hold_word[BYTE_W-1:0] : hold_word[WORD_W-1:BYTE_W];
        end
    end

endmodule

// File: rtl/byte_link_arbiter.sv
// byte_link_arbiter
// Round-robin arbiter that serialises 16-bit words from NREQ requesters into
// a byte stream, high byte first.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   ready_req     per-requester word valid, held until its accepted_req pulse
//   in_req        flattened words, requester i at [16*i+15:16*i]
//   accepted_req  one-hot single-cycle acknowledge of the captured word
//   accepted_in   downstream acceptance of the current byte
//   ready_out     out_byte is valid
//   out_byte      current byte, 0 whenever ready_out is low
//   grant_id      requester whose word is in flight, 0 when idle
//   busy          high whenever the FSM is not idle
module byte_link_arbiter
    import byte_link_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int GW   = $clog2(NREQ)
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        ready_req,
    input  logic [WORD_W*NREQ-1:0] in_req,
    output logic [NREQ-1:0]        accepted_req,
    input  logic                   accepted_in,
    output logic                   ready_out,
    output logic [BYTE_W-1:0]      out_byte,
    output logic [GW-1:0]          grant_id,
    output logic                   busy
);

    state_t            state;
    state_t            state_n;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     rr_pick;
    logic              rr_found;
    int                rr_idx;
    logic [WORD_W-1:0] sel_word;
    logic              load_word;
    logic              advance;
    logic              byte_cnt;

    // Round-robin search begins just after the previous winner and wraps,
    // so a lone requester is still picked again on the next pass.
    always_comb begin
        rr_pick  = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = (int'(last_grant) + k) % NREQ;
            if (!rr_found && ready_req[GW'(rr_idx)]) begin
                rr_pick  = GW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    // Constant-index mux keeps the word select free of wide variable slices.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == GW'(i)) begin
                sel_word = in_req[i*WORD_W +: WORD_W];
            end
        end
    end

    // Grant and last_grant move together on leaving IDLE; ready_req is not
    // looked at again until the word has been fully sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NREQ - 1);
        end else begin
            state <= state_n;
            if (state == IDLE && rr_found) begin
                grant      <= rr_pick;
                last_grant <= rr_pick;
            end
        end
    end

    // Next-state and Moore outputs; accepted_in only matters in SEND.
    always_comb begin
        state_n      = state;
        load_word    = 1'b0;
        advance      = 1'b0;
        ready_out    = 1'b0;
        accepted_req = '0;
        case (state)
            IDLE: begin
                if (rr_found) state_n = LOAD;
            end
            LOAD: begin
                load_word = 1'b1;
                state_n   = ACK;
            end
            ACK: begin
                for (int i = 0; i < NREQ; i++) begin
                    accepted_req[i] = (grant == GW'(i));
                end
                state_n = SEND;
            end
            SEND: begin
                ready_out = 1'b1;
                if (accepted_in) state_n = COUNT;
            end
            COUNT: begin
                advance = 1'b1;
                state_n = byte_cnt ? IDLE : SEND;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign grant_id = (state == IDLE) ? '0 : grant;

    byte_link_dp u_dp (
        .clk       (clk),
        .rst       (rst),
        .load_word (load_word),
        .advance   (advance),
        .drive_out (ready_out),
        .word_in   (sel_word),
        .out_byte  (out_byte),
        .byte_cnt  (byte_cnt)
    );

endmodule

// File: tb/tb_byte_link_arbiter.sv
// tb_byte_link_arbiter
// Directed bench for byte_link_arbiter: a 2-requester instance for the main
// scenarios and a 4-requester instance for round-robin fairness.
module tb_byte_link_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [1:0]  ready_req;
    logic [31:0] in_req;
    logic [1:0]  accepted_req;
    logic        accepted_in;
    logic        ready_out;
    logic [7:0]  out_byte;
    logic        grant_id;
    logic        busy;

    logic [3:0]  ready4;
    logic [63:0] in4;
    logic [3:0]  acc4;
    logic        accin4;
    logic        rdy4;
    logic [7:0]  out4;
    logic [1:0]  gid4;
    logic        busy4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    byte_link_arbiter #(.NREQ(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .ready_req    (ready_req),
        .in_req       (in_req),
        .accepted_req (accepted_req),
        .accepted_in  (accepted_in),
        .ready_out    (ready_out),
        .out_byte     (out_byte),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    byte_link_arbiter #(.NREQ(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .ready_req    (ready4),
        .in_req       (in4),
        .accepted_req (acc4),
        .accepted_in  (accin4),
        .ready_out    (rdy4),
        .out_byte     (out4),
        .grant_id     (gid4),
        .busy         (busy4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Outputs are Moore, so sampling 2 time units after the edge is safe.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [31:0] words, input logic acc);
        ready_req   = req;
        in_req      = words;
        accepted_in = acc;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(2'b00, 32'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Walks one full word from IDLE with accepted_in high; req_after_load is
    // applied once LOAD is reached.
    task automatic serveWord(input int g, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [1:0] req_after_load, input string tag);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
        tick();
        ready_req = req_after_load;
        checkOutput({tag, "_load_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_grant"}, 32'(grant_id), 32'(g));
        checkOutput({tag, "_load_acc"}, 32'(accepted_req), 32'd0);
        tick();
        checkOutput({tag, "_ack"}, 32'(accepted_req), 32'd1 << g);
        checkOutput({tag, "_ack_rdy"}, 32'(ready_out), 32'd0);
        tick();
        checkOutput({tag, "_send_rdy"}, 32'(ready_out), 32'd1);
        checkOutput({tag, "_hi"}, 32'(out_byte), 32'(hi));
        checkOutput({tag, "_send_acc"}, 32'(accepted_req), 32'd0);
        tick();
        checkOutput({tag, "_cnt_rdy"}, 32'(ready_out), 32'd0);
        checkOutput({tag, "_cnt_byte"}, 32'(out_byte), 32'd0);
        tick();
        checkOutput({tag, "_lo"}, 32'(out_byte), 32'(lo));
        tick();
        checkOutput({tag, "_cnt2_busy"}, 32'(busy), 32'd1);
        tick();
        checkOutput({tag, "_done_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done_gid"}, 32'(grant_id), 32'd0);
    endtask

    initial begin
        ready4 = 4'h0;
        in4    = '0;
        accin4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in4[16*i +: 16] = {8'(8'hA0 + i), 8'(8'h50 + i)};
        end

        // Reset values
        doReset();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rdy", 32'(ready_out), 32'd0);
        checkOutput("rst_byte", 32'(out_byte), 32'd0);
        checkOutput("rst_gid", 32'(grant_id), 32'd0);
        checkOutput("rst_acc", 32'(accepted_req), 32'd0);
        checkOutput("rst4_busy", 32'(busy4), 32'd0);

        // Fairness on the 4-requester instance: 0,1,2,3,0,1,2,3
        ready4 = 4'hF;
        for (int w = 0; w < 8; w++) begin
            tick();
            checkOutput("fair_gid", 32'(gid4), 32'(w % 4));
            tick();
            checkOutput("fair_ack", 32'(acc4), 32'd1 << (w % 4));
            tick();
            checkOutput("fair_hi", 32'(out4), 32'(8'hA0 + (w % 4)));
            tick();
            tick();
            checkOutput("fair_lo", 32'(out4), 32'(8'h50 + (w % 4)));
            tick();
            tick();
            checkOutput("fair_idle", 32'(busy4), 32'd0);
        end
        ready4 = 4'h0;

        // Single request, requester drops ready_req during LOAD
        doReset();
        applyStimulus(2'b01, {16'h0000, 16'hA55A}, 1'b1);
        serveWord(0, 8'hA5, 8'h5A, 2'b00, "single");

        // Contention from reset: requester 0 first, then requester 1
        doReset();
        applyStimulus(2'b11, {16'h3344, 16'h1122}, 1'b1);
        serveWord(0, 8'h11, 8'h22, 2'b11, "cont0");
        serveWord(1, 8'h33, 8'h44, 2'b00, "cont1");

        // Lone requester served back-to-back
        applyStimulus(2'b01, {16'h0000, 16'h6789}, 1'b1);
        serveWord(0, 8'h67, 8'h89, 2'b01, "b2b0");
        serveWord(0, 8'h67, 8'h89, 2'b00, "b2b1");

        // Backpressure: byte held for 5 cycles in SEND
        doReset();
        applyStimulus(2'b01, {16'h0000, 16'hA55A}, 1'b0);
        tick();
        ready_req = 2'b00;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rdy", 32'(ready_out), 32'd1);
            checkOutput("bp_hold", 32'(out_byte), 32'hA5);
            tick();
        end
        checkOutput("bp_still", 32'(out_byte), 32'hA5);
        accepted_in = 1'b1;
        tick();
        checkOutput("bp_cnt", 32'(ready_out), 32'd0);
        tick();
        checkOutput("bp_lo", 32'(out_byte), 32'h5A);
        tick();
        tick();
        checkOutput("bp_idle", 32'(busy), 32'd0);

        // Spurious accepted_in in IDLE/LOAD/ACK, then stalls in SEND
        doReset();
        applyStimulus(2'b01, {16'h0000, 16'h9ABC}, 1'b1);
        tick();
        ready_req = 2'b00;
        checkOutput("spur_load_rdy", 32'(ready_out), 32'd0);
        tick();
        checkOutput("spur_ack", 32'(accepted_req), 32'd1);
        accepted_in = 1'b0;
        tick();
        checkOutput("spur_hi", 32'(out_byte), 32'h9A);
        tick();
        checkOutput("spur_hi_held", 32'(out_byte), 32'h9A);
        accepted_in = 1'b1;
        tick();
        checkOutput("spur_cnt", 32'(ready_out), 32'd0);
        accepted_in = 1'b0;
        tick();
        checkOutput("spur_lo", 32'(out_byte), 32'hBC);
        tick();
        checkOutput("spur_lo_held", 32'(out_byte), 32'hBC);
        accepted_in = 1'b1;
        tick();
        tick();
        checkOutput("spur_idle", 32'(busy), 32'd0);

        // Reset after the first byte discards the word
        doReset();
        applyStimulus(2'b01, {16'h0000, 16'hC3D4}, 1'b1);
        tick();
        ready_req = 2'b00;
        tick();
        tick();
        checkOutput("mid_hi", 32'(out_byte), 32'hC3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_rdy", 32'(ready_out), 32'd0);
        checkOutput("mid_byte", 32'(out_byte), 32'd0);
        checkOutput("mid_gid", 32'(grant_id), 32'd0);
        checkOutput("mid_acc", 32'(accepted_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mid_quiet_rdy", 32'(ready_out), 32'd0);
            checkOutput("mid_quiet_busy", 32'(busy), 32'd0);
        end
        applyStimulus(2'b11, {16'h5566, 16'h7788}, 1'b1);
        serveWord(0, 8'h77, 8'h88, 2'b00, "mid_next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
